alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequential front/back stage wrapped around the combinational 8-bit ALU (operand_A, operand_B, Sel in; Out, Flag out).
- Accepts operation commands over a valid/ready handshake and registers them onto the ALU inputs.
- Holds the operands stable for a programmable settle time, then captures Out/Flag into a result register presented over a second valid/ready handshake.
- Keeps an accumulator so chained operations can reuse the previous result as operand A.

Parameters:
- DATA_W, 8, operand/result width (matches ALU operand_A/operand_B/Out).
- SEL_W, 4, opcode width (matches ALU Sel).
- FLAG_W, 4, flag width (matches ALU Flag).
- SETTLE_CYCLES, 1, clock edges between command accept and result capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_sel  in  SEL_W  ALU opcode.
- cmd_acc  in  1  1 = use accumulator instead of cmd_a as operand A.
- alu_operand_A  out  DATA_W  to ALU operand_A.
- alu_operand_B  out  DATA_W  to ALU operand_B.
- alu_sel  out  SEL_W  to ALU Sel.
- alu_out  in  DATA_W  from ALU Out.
- alu_flag  in  FLAG_W  from ALU Flag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_W  captured ALU Out.
- res_flag  out  FLAG_W  captured ALU Flag.
- acc_q  out  DATA_W  accumulator value.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: state=IDLE; cmd_ready=1 (combinational from state); res_valid=0; res_data, res_flag, acc_q, alu_operand_A, alu_operand_B, alu_sel all 0; settle counter 0.
- FSM states IDLE, ISSUE, HOLD. cmd_ready = (state==IDLE). res_valid = (state==HOLD).
- IDLE:
  - Accept is the edge where cmd_valid && cmd_ready.
  - On accept: alu_operand_A <= cmd_acc ? acc_q : cmd_a; alu_operand_B <= cmd_b; alu_sel <= cmd_sel; counter <= SETTLE_CYCLES-1; state -> ISSUE.
  - cmd_acc samples the acc_q value present at the accept edge.
- ISSUE:
  - If counter != 0: counter decrements.
  - If counter == 0: res_data <= alu_out; res_flag <= alu_flag; acc_q <= alu_out; state -> HOLD.
- Latency: the capture edge is exactly SETTLE_CYCLES edges after the accept edge. res_valid is high in the cycle following capture.
- HOLD:
  - res_data/res_flag are held stable until the edge where res_ready=1; then state -> IDLE.
  - res_ready=0 stalls indefinitely with no data change.
  - cmd_ready is 0 throughout HOLD; no command is lost or overwritten.
- Throughput: one command per SETTLE_CYCLES+2 cycles when res_ready is tied high.
- Operand outputs change only on an accept edge or reset. They hold their last values through HOLD and IDLE.
- Arithmetic: the block does no arithmetic; the accumulator takes the full DATA_W ALU result, with no extension or truncation beyond DATA_W.
- res_ready asserted outside HOLD is ignored. cmd_valid asserted outside IDLE is ignored, and the command is not accepted.
- Reset mid-operation (ISSUE or HOLD) abandons the operation: no capture, res_valid drops to 0 in the next cycle, acc_q is cleared to 0.
- rst has priority over every other event on the same edge.

Test Plan:
Bench uses an ALU stub with alu_out = alu_operand_A + alu_operand_B (mod 256) and alu_flag = alu_sel.
- Reset then idle: rst=1 for 2 cycles -> cmd_ready=1, res_valid=0, acc_q=0x00, all ALU drive outputs 0x00/0x0.
- Single op, SETTLE_CYCLES=1: accept a=0x12, b=0x34, sel=0x2 at edge T -> capture at T+1, res_valid high after T+1, res_data=0x46, res_flag=0x2, acc_q=0x46.
- Accumulate with wrap: first op 0xFF+0x01 -> res_data=0x00. Then op cmd_acc=1, a=0xAA (ignored), b=0x05 -> alu_operand_A=0x00, res_data=0x05, acc_q=0x05.
- Backpressure: hold res_ready=0 for 6 cycles after a result -> res_valid stays 1, res_data unchanged, cmd_ready=0, and a cmd_valid pulse is not accepted. Raise res_ready -> IDLE next cycle, cmd_ready=1.
- Settle latency, SETTLE_CYCLES=3: accept at edge T -> capture exactly at T+3. Changing the stub output before T+3 only affects what is captured at T+3.
- Reset mid-op: rst during ISSUE -> no res_valid, acc_q=0x00. A new command after reset completes normally: 0x10+0x20 -> res_data=0x30.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/capture wrapper around a combinational ALU: registers commands onto the
// ALU inputs, waits a settle time, captures Out/Flag and offers them over valid/ready.
module alu_issue_ctrl #(
    parameter int DATA_W        = 8,
    parameter int SEL_W         = 4,
    parameter int FLAG_W        = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic              cmd_acc,
    output logic [DATA_W-1:0] alu_operand_A,
    output logic [DATA_W-1:0] alu_operand_B,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [FLAG_W-1:0] res_flag,
    output logic [DATA_W-1:0] acc_q
);

    // state | meaning
    // IDLE  | ready for a command; operand outputs hold their last values
    // ISSUE | operands driven onto the ALU, settle counter running
    // HOLD  | result captured and valid, waiting for res_ready

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   opa_q;
    logic [DATA_W-1:0]   opb_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   res_data_q;
    logic [FLAG_W-1:0]   res_flag_q;
    logic [DATA_W-1:0]   acc_val_q;
    logic [DATA_W-1:0]   opa_d;

    // Operand A source is decided from the accumulator value present at the accept edge.
    assign opa_d = cmd_acc ? acc_val_q : cmd_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            sel_q      <= '0;
            res_data_q <= '0;
            res_flag_q <= '0;
            acc_val_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        opa_q   <= opa_d;
                        opb_q   <= cmd_b;
                        sel_q   <= cmd_sel;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        res_data_q <= alu_out;
                        res_flag_q <= alu_flag;
                        acc_val_q  <= alu_out;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign res_valid     = (state_q == HOLD);
    assign alu_operand_A = opa_q;
    assign alu_operand_B = opb_q;
    assign alu_sel       = sel_q;
    assign res_data      = res_data_q;
    assign res_flag      = res_flag_q;
    assign acc_q         = acc_val_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (settle 1 and 3) on adder stubs, checked by
// vector table, hand-written corner sequences and a transaction-level random model.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [7:0] cmd_a, cmd_b;
    logic [3:0] cmd_sel;
    logic       cmd_acc;
    logic       res_ready;
    logic [7:0] stub_off;
    logic       which;

    logic       d1_cmd_ready, d1_res_valid, d3_cmd_ready, d3_res_valid;
    logic [7:0] d1_opa, d1_opb, d1_out, d1_res_data, d1_acc;
    logic [7:0] d3_opa, d3_opb, d3_out, d3_res_data, d3_acc;
    logic [3:0] d1_sel, d1_flag, d1_res_flag, d3_sel, d3_flag, d3_res_flag;

    logic       cur_cmd_ready, cur_res_valid;
    logic [7:0] cur_opa, cur_opb, cur_res_data, cur_acc;
    logic [3:0] cur_sel, cur_res_flag;
    int         cur_settle;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] macc;

    always #5 clk = ~clk;

    // ALU stubs: sum of operands plus a bench-controlled offset, flag mirrors the opcode
    assign d1_out  = d1_opa + d1_opb + stub_off;
    assign d1_flag = d1_sel;
    assign d3_out  = d3_opa + d3_opb + stub_off;
    assign d3_flag = d3_sel;

    alu_issue_ctrl #(.DATA_W(8), .SEL_W(4), .FLAG_W(4), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(d1_cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_acc(cmd_acc),
        .alu_operand_A(d1_opa), .alu_operand_B(d1_opb), .alu_sel(d1_sel),
        .alu_out(d1_out), .alu_flag(d1_flag), .res_valid(d1_res_valid),
        .res_ready(res_ready), .res_data(d1_res_data), .res_flag(d1_res_flag),
        .acc_q(d1_acc));

    alu_issue_ctrl #(.DATA_W(8), .SEL_W(4), .FLAG_W(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(d3_cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_acc(cmd_acc),
        .alu_operand_A(d3_opa), .alu_operand_B(d3_opb), .alu_sel(d3_sel),
        .alu_out(d3_out), .alu_flag(d3_flag), .res_valid(d3_res_valid),
        .res_ready(res_ready), .res_data(d3_res_data), .res_flag(d3_res_flag),
        .acc_q(d3_acc));

    always_comb begin
        cur_cmd_ready = which ? d3_cmd_ready : d1_cmd_ready;
        cur_res_valid = which ? d3_res_valid : d1_res_valid;
        cur_opa       = which ? d3_opa       : d1_opa;
        cur_opb       = which ? d3_opb       : d1_opb;
        cur_sel       = which ? d3_sel       : d1_sel;
        cur_res_data  = which ? d3_res_data  : d1_res_data;
        cur_res_flag  = which ? d3_res_flag  : d1_res_flag;
        cur_acc       = which ? d3_acc       : d1_acc;
        cur_settle    = which ? 3 : 1;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic       acc;
        logic [7:0] exp_opa;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        macc = 8'h00;
    endtask

    task automatic issue_and_capture(input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] sel, input logic acc,
                                     input logic [7:0] exp_opa, input logic [7:0] exp_data,
                                     input string nm);
        int k;
        k = 0;
        while (!cur_cmd_ready && k < 50) begin
            tick();
            k++;
        end
        chk({nm, "_idle_ready"}, 16'(cur_cmd_ready), 16'd1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_acc   = acc;
        tick();
        cmd_valid = 1'b0;
        chk({nm, "_opa"}, 16'(cur_opa), 16'(exp_opa));
        chk({nm, "_opb"}, 16'(cur_opb), 16'(b));
        chk({nm, "_sel"}, 16'(cur_sel), 16'(sel));
        chk({nm, "_busy"}, 16'(cur_cmd_ready), 16'd0);
        k = 0;
        while (!cur_res_valid && k < 40) begin
            res_ready = 1'($urandom % 2);
            tick();
            k++;
        end
        res_ready = 1'b0;
        chk({nm, "_latency"}, 16'(k), 16'(cur_settle));
        chk({nm, "_data"}, 16'(cur_res_data), 16'(exp_data));
        chk({nm, "_flag"}, 16'(cur_res_flag), 16'(sel));
        chk({nm, "_acc"}, 16'(cur_acc), 16'(exp_data));
    endtask

    task automatic release_result(input string nm);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({nm, "_rel_ready"}, 16'(cur_cmd_ready), 16'd1);
        chk({nm, "_rel_valid"}, 16'(cur_res_valid), 16'd0);
    endtask

    task automatic random_ops(input int n, input string nm);
        logic [7:0] a, b, opa, exp;
        logic [3:0] sel;
        logic       acc;
        int         stall;
        for (int i = 0; i < n; i++) begin
            a    = 8'($urandom);
            b    = 8'($urandom);
            sel  = 4'($urandom);
            acc  = 1'($urandom % 2);
            opa  = acc ? macc : a;
            exp  = 8'((32'(opa) + 32'(b)) % 256);
            macc = exp;
            issue_and_capture(a, b, sel, acc, opa, exp, nm);
            stall = int'($urandom % 4);
            for (int s = 0; s < stall; s++) begin
                cmd_valid = 1'($urandom % 2);
                cmd_a     = 8'($urandom);
                cmd_b     = 8'($urandom);
                tick();
                chk({nm, "_stall_data"}, 16'(cur_res_data), 16'(exp));
                chk({nm, "_stall_opa"}, 16'(cur_opa), 16'(opa));
            end
            cmd_valid = 1'b0;
            release_result(nm);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a: 8'h12, b: 8'h34, sel: 4'h2, acc: 1'b0, exp_opa: 8'h12, exp_data: 8'h46};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sel: 4'h7, acc: 1'b0, exp_opa: 8'hFF, exp_data: 8'h00};
        vecs[2] = '{a: 8'hAA, b: 8'h05, sel: 4'h3, acc: 1'b1, exp_opa: 8'h00, exp_data: 8'h05};
        vecs[3] = '{a: 8'h80, b: 8'h80, sel: 4'hF, acc: 1'b0, exp_opa: 8'h80, exp_data: 8'h00};
        vecs[4] = '{a: 8'h33, b: 8'h7F, sel: 4'h9, acc: 1'b1, exp_opa: 8'h00, exp_data: 8'h7F};
        vecs[5] = '{a: 8'h01, b: 8'hFE, sel: 4'h0, acc: 1'b1, exp_opa: 8'h7F, exp_data: 8'h7D};

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_acc = 1'b0;
        res_ready = 1'b0; stub_off = 8'h00; which = 1'b0;
        do_reset();

        for (int w = 0; w < 2; w++) begin
            which = 1'(w);
            #1;
            chk("rst_cmd_ready", 16'(cur_cmd_ready), 16'd1);
            chk("rst_res_valid", 16'(cur_res_valid), 16'd0);
            chk("rst_acc", 16'(cur_acc), 16'h00);
            chk("rst_opa", 16'(cur_opa), 16'h00);
            chk("rst_opb", 16'(cur_opb), 16'h00);
            chk("rst_sel", 16'(cur_sel), 16'h0);
            chk("rst_res_data", 16'(cur_res_data), 16'h00);
            chk("rst_res_flag", 16'(cur_res_flag), 16'h0);
        end

        which = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            issue_and_capture(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].acc,
                              vecs[i].exp_opa, vecs[i].exp_data, $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        issue_and_capture(8'h20, 8'h03, 4'h5, 1'b0, 8'h20, 8'h23, "bp");
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                cmd_valid = 1'b1; cmd_a = 8'h99; cmd_b = 8'h11; cmd_acc = 1'b0;
            end
            tick();
            cmd_valid = 1'b0;
            chk("bp_valid", 16'(cur_res_valid), 16'd1);
            chk("bp_data", 16'(cur_res_data), 16'h23);
            chk("bp_ready", 16'(cur_cmd_ready), 16'd0);
            chk("bp_opa", 16'(cur_opa), 16'h20);
        end
        release_result("bp");
        chk("bp_opa_after", 16'(cur_opa), 16'h20);
        macc = 8'h23;
        random_ops(30, "rnd1");

        which = 1'b1;
        do_reset();
        issue_and_capture(8'h10, 8'h01, 4'h3, 1'b0, 8'h10, 8'h11, "settle_base");
        release_result("settle_base");
        cmd_valid = 1'b1; cmd_a = 8'h10; cmd_b = 8'h01; cmd_sel = 4'h6; cmd_acc = 1'b0;
        tick();
        cmd_valid = 1'b0;
        stub_off = 8'h40;
        tick();
        chk("settle_t1_valid", 16'(cur_res_valid), 16'd0);
        stub_off = 8'h05;
        tick();
        chk("settle_t2_valid", 16'(cur_res_valid), 16'd0);
        tick();
        chk("settle_t3_valid", 16'(cur_res_valid), 16'd1);
        chk("settle_t3_data", 16'(cur_res_data), 16'h16);
        chk("settle_t3_flag", 16'(cur_res_flag), 16'h6);
        chk("settle_t3_acc", 16'(cur_acc), 16'h16);
        stub_off = 8'h00;
        tick();
        chk("settle_hold_data", 16'(cur_res_data), 16'h16);
        release_result("settle");

        cmd_valid = 1'b1; cmd_a = 8'h55; cmd_b = 8'h66; cmd_sel = 4'h1; cmd_acc = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 16'(cur_res_valid), 16'd0);
        chk("midrst_acc", 16'(cur_acc), 16'h00);
        chk("midrst_ready", 16'(cur_cmd_ready), 16'd1);
        chk("midrst_opa", 16'(cur_opa), 16'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_valid", 16'(cur_res_valid), 16'd0);
        end
        macc = 8'h00;
        issue_and_capture(8'h10, 8'h20, 4'h4, 1'b0, 8'h10, 8'h30, "post_rst");
        release_result("post_rst");
        macc = 8'h30;
        random_ops(30, "rnd3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
